// File: rtl/pixel_axi4_master_tx.sv
// rtl/pixel_axi4_master_tx.sv - packs downscaled grayscale pixels into words and writes them as fixed-length AXI4 INCR bursts
module pixel_axi4_master_tx #(
  parameter int                GS_PXL_W  = 8,
  parameter int                COL_NUM   = 640,
  parameter int                ROW_NUM   = 480,
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GS_PXL_W-1:0]   pds_pxl_i,
  input  logic                  pds_pxl_vld_i,
  output logic                  pds_pxl_rdy_o,
  output logic [ADDR_W-1:0]     m_awaddr_o,
  output logic [7:0]            m_awlen_o,
  output logic [2:0]            m_awsize_o,
  output logic [1:0]            m_awburst_o,
  output logic                  m_awvalid_o,
  input  logic                  m_awready_i,
  output logic [DATA_W-1:0]     m_wdata_o,
  output logic [DATA_W/8-1:0]   m_wstrb_o,
  output logic                  m_wlast_o,
  output logic                  m_wvalid_o,
  input  logic                  m_wready_i,
  input  logic [1:0]            m_bresp_i,
  input  logic                  m_bvalid_i,
  output logic                  m_bready_o,
  output logic                  frame_done_o,
  output logic                  err_o
);

  localparam int PPW          = DATA_W / GS_PXL_W;
  localparam int DEPTH        = 2 * BURST_LEN;
  localparam int PTR_W        = $clog2(DEPTH);
  localparam int PC_W         = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BT_W         = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int FRAME_BURSTS = (COL_NUM / 2) * (ROW_NUM / 2) / (PPW * BURST_LEN);
  localparam int BC_W         = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BURST_LEN * DATA_W / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t              state, state_n;
  logic [PC_W-1:0]     pack_cnt;
  logic [DATA_W-1:0]   pack_buf;
  logic [DATA_W-1:0]   push_word;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      fifo_cnt;
  logic [BT_W-1:0]     beat_cnt;
  logic [BC_W-1:0]     burst_cnt;
  logic                last_pxl, pxl_hs, push, pop, fifo_full, beat_last, b_hs;

  assign last_pxl      = (pack_cnt == PC_W'(PPW - 1));
  assign fifo_full     = (fifo_cnt == (PTR_W + 1)'(DEPTH));
  assign pds_pxl_rdy_o = ~(last_pxl & fifo_full);
  assign pxl_hs        = pds_pxl_vld_i & pds_pxl_rdy_o;
  assign push          = pxl_hs & last_pxl;
  assign pop           = m_wvalid_o & m_wready_i;
  assign beat_last     = (beat_cnt == BT_W'(BURST_LEN - 1));
  assign b_hs          = (state == RESP) & m_bvalid_i;

  assign m_awlen_o   = 8'(BURST_LEN - 1);
  assign m_awsize_o  = 3'($clog2(DATA_W / 8));
  assign m_awburst_o = 2'b01;
  assign m_wstrb_o   = '1;
  assign m_wdata_o   = mem[rd_ptr];

  // The final pixel bypasses pack_buf so the completed word is pushed on its own handshake
  always_comb begin
    push_word = pack_buf;
    push_word[(PPW-1)*GS_PXL_W +: GS_PXL_W] = pds_pxl_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_cnt <= '0;
      pack_buf <= '0;
    end else if (pxl_hs) begin
      if (last_pxl) begin
        pack_cnt <= '0;
      end else begin
        pack_buf[pack_cnt*GS_PXL_W +: GS_PXL_W] <= pds_pxl_i;
        pack_cnt <= pack_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n     = state;
    m_awvalid_o = 1'b0;
    m_wvalid_o  = 1'b0;
    m_wlast_o   = 1'b0;
    m_bready_o  = 1'b0;
    case (state)
      IDLE: if (fifo_cnt >= (PTR_W + 1)'(BURST_LEN)) state_n = ADDR;
      ADDR: begin
        m_awvalid_o = 1'b1;
        if (m_awready_i) state_n = DATA;
      end
      DATA: begin
        m_wvalid_o = 1'b1;
        m_wlast_o  = beat_last;
        if (m_wready_i && beat_last) state_n = RESP;
      end
      RESP: begin
        m_bready_o = 1'b1;
        if (m_bvalid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Address and burst count wrap together so each frame overwrites the same region
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt     <= '0;
      burst_cnt    <= '0;
      m_awaddr_o   <= BASE_ADDR;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (pop) beat_cnt <= beat_last ? '0 : beat_cnt + 1'b1;
      if (b_hs) begin
        if (m_bresp_i != 2'b00) err_o <= 1'b1;
        if (burst_cnt == BC_W'(FRAME_BURSTS - 1)) begin
          burst_cnt    <= '0;
          m_awaddr_o   <= BASE_ADDR;
          frame_done_o <= 1'b1;
        end else begin
          burst_cnt  <= burst_cnt + 1'b1;
          m_awaddr_o <= m_awaddr_o + ADDR_STEP;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_axi4_master_tx.sv
// tb/tb_pixel_axi4_master_tx.sv - scoreboard bench for pixel_axi4_master_tx on a 16x8 frame with 4-beat bursts
module tb_pixel_axi4_master_tx;

  localparam int GS_PXL_W = 8;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 32;
  localparam int BLEN     = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        pds_pxl_i;
  logic              pds_pxl_vld_i, pds_pxl_rdy_o;
  logic [31:0]       m_awaddr_o;
  logic [7:0]        m_awlen_o;
  logic [2:0]        m_awsize_o;
  logic [1:0]        m_awburst_o;
  logic              m_awvalid_o, m_awready_i;
  logic [31:0]       m_wdata_o;
  logic [3:0]        m_wstrb_o;
  logic              m_wlast_o, m_wvalid_o, m_wready_i;
  logic [1:0]        m_bresp_i;
  logic              m_bvalid_i, m_bready_o, frame_done_o, err_o;

  always #5 clk = ~clk;

  pixel_axi4_master_tx #(
    .GS_PXL_W(GS_PXL_W), .COL_NUM(16), .ROW_NUM(8), .DATA_W(DATA_W),
    .ADDR_W(ADDR_W), .BASE_ADDR(32'h1000), .BURST_LEN(BLEN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .pds_pxl_i(pds_pxl_i), .pds_pxl_vld_i(pds_pxl_vld_i), .pds_pxl_rdy_o(pds_pxl_rdy_o),
    .m_awaddr_o(m_awaddr_o), .m_awlen_o(m_awlen_o), .m_awsize_o(m_awsize_o),
    .m_awburst_o(m_awburst_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
    .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wlast_o(m_wlast_o),
    .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
    .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
    .frame_done_o(frame_done_o), .err_o(err_o)
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_aw_q[$];
  logic [32:0] exp_w_q[$];

  logic [31:0] mdl_word;
  int mdl_pix = 0, mdl_words = 0, mdl_bursts = 0, exp_frames = 0;
  int pval = 0;
  int aw_hs = 0, w_beats = 0, b_hs = 0, fd_count = 0, acc_pixels = 0;
  logic fd_prev = 1'b0;
  logic feeder_done, bflip_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Expected values are built per accepted pixel: words little-endian, bursts at 0x1000/0x1010
  task automatic model_pixel(input logic [7:0] p);
    mdl_word[mdl_pix*8 +: 8] = p;
    mdl_pix++;
    if (mdl_pix == 4) begin
      exp_w_q.push_back({(mdl_words % BLEN) == BLEN - 1, mdl_word});
      mdl_words++;
      mdl_pix = 0;
      if (mdl_words % BLEN == 0) begin
        exp_aw_q.push_back(32'h1000 + 32'h10 * (mdl_bursts % 2));
        mdl_bursts++;
        if (mdl_bursts % 2 == 0) exp_frames++;
      end
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the handshake edge
  task automatic send_pixel(input logic [7:0] p);
    int g;
    pds_pxl_i = p;
    pds_pxl_vld_i = 1'b1;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!pds_pxl_rdy_o && g < 1000);
    if (g >= 1000) fail_now("pxl_timeout");
    @(posedge clk);
    #1;
    model_pixel(p);
    pds_pxl_vld_i = 1'b0;
  endtask

  task automatic feed(input int n);
    for (int i = 0; i < n; i++) begin
      send_pixel(8'(pval));
      pval++;
    end
  endtask

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int g;
    g = 0;
    while ((exp_aw_q.size() != 0 || exp_w_q.size() != mdl_words % BLEN || m_bready_o) && g < 2000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 2000) fail_now("drain_timeout");
    repeat (4) @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pds_pxl_vld_i && pds_pxl_rdy_o) acc_pixels++;
        if (m_awvalid_o && m_awready_i) begin
          aw_hs++;
          if (exp_aw_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL aw_unexpected actual=%0h required=none", m_awaddr_o);
          end else begin
            check("aw_addr", m_awaddr_o, exp_aw_q.pop_front());
          end
          check("aw_len", m_awlen_o, 8'd3);
          check("aw_size", m_awsize_o, 3'd2);
          check("aw_burst", m_awburst_o, 2'b01);
        end
        if (m_wvalid_o && m_wready_i) begin
          check("w_after_aw", w_beats < aw_hs * BLEN, 1'b1);
          if (exp_w_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL w_unexpected actual=%0h required=none", m_wdata_o);
          end else begin
            e = exp_w_q.pop_front();
            check("w_data", m_wdata_o, e[31:0]);
            check("w_last", m_wlast_o, e[32]);
          end
          check("w_strb", m_wstrb_o, 4'hf);
          w_beats++;
        end
        if (m_bvalid_i && m_bready_o) b_hs++;
        if (frame_done_o) begin
          fd_count++;
          if (fd_prev) check("frame_done_width", 2, 1);
        end
        fd_prev = frame_done_o;
      end
    end
  end

  initial begin
    int g, acc0, w0, b0;
    rst_n = 1'b0;
    pds_pxl_i = '0; pds_pxl_vld_i = 1'b0;
    m_awready_i = 1'b1; m_wready_i = 1'b1;
    m_bresp_i = 2'b00; m_bvalid_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_awvalid", m_awvalid_o, 0);
    check("rst_wvalid", m_wvalid_o, 0);
    check("rst_wlast", m_wlast_o, 0);
    check("rst_bready", m_bready_o, 0);
    check("rst_frame_done", frame_done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_awaddr", m_awaddr_o, 32'h1000);
    check("rst_pxl_rdy", pds_pxl_rdy_o, 1);
    rst_n = 1'b1;
    sync;

    // Two frames back to back, all ready
    feed(32);
    drain;
    check("frame1_done_count", fd_count, exp_frames);
    sync;
    feed(32);
    drain;
    check("frame2_done_count", fd_count, exp_frames);

    // AW stall: valid and address hold, no W beat leaks out
    sync;
    m_awready_i = 1'b0;
    feed(16);
    g = 0;
    while (!m_awvalid_o && g < 100) begin @(negedge clk); #1; g++; end
    if (g >= 100) fail_now("awvalid_timeout");
    repeat (5) begin
      @(negedge clk); #1;
      check("aw_stall_valid", m_awvalid_o, 1);
      check("aw_stall_addr", m_awaddr_o, 32'h1000);
      check("aw_stall_no_w", m_wvalid_o, 0);
    end
    sync;
    m_awready_i = 1'b1;
    feed(16);
    drain;
    check("frame3_done_count", fd_count, exp_frames);
    check("err_clean", err_o, 0);

    // W stall: intake stops after 8 buffered words + 3 pixels
    sync;
    m_wready_i = 1'b0;
    acc0 = acc_pixels;
    feeder_done = 1'b0;
    fork
      begin feed(40); feeder_done = 1'b1; end
    join_none
    g = 0;
    do begin @(negedge clk); #1; g++; end
    while (!(pds_pxl_vld_i && !pds_pxl_rdy_o) && g < 200);
    if (g >= 200) fail_now("rdy_drop_timeout");
    check("accepted_before_stall", acc_pixels - acc0, 35);
    @(posedge clk); #1;
    m_wready_i = 1'b1;
    @(negedge clk); #1;
    check("rdy_low_before_pop", pds_pxl_rdy_o, 0);
    check("wvalid_at_pop", m_wvalid_o, 1);
    @(negedge clk); #1;
    check("rdy_rise_after_pop", pds_pxl_rdy_o, 1);
    g = 0;
    while (!feeder_done && g < 1000) begin @(negedge clk); g++; end
    if (g >= 1000) fail_now("feeder_timeout");
    drain;
    check("frame4_done_count", fd_count, exp_frames);
    check("accepted_total", acc_pixels - acc0, 40);

    // SLVERR on the first burst of frame 5
    sync;
    m_bresp_i = 2'b10;
    bflip_done = 1'b0;
    b0 = b_hs;
    fork
      begin
        int gb;
        gb = 0;
        while (b_hs == b0 && gb < 2000) begin @(negedge clk); gb++; end
        @(posedge clk); #1;
        m_bresp_i = 2'b00;
        bflip_done = 1'b1;
      end
    join_none
    feed(24);
    drain;
    check("bflip_done", bflip_done, 1);
    check("err_set", err_o, 1);
    check("frame5_done_count", fd_count, exp_frames);
    repeat (10) @(negedge clk);
    #1;
    check("err_sticky", err_o, 1);

    // Reset while beat 2 of a burst is on the bus
    sync;
    feed(16);
    w0 = w_beats;
    g = 0;
    while (w_beats < w0 + 2 && g < 200) begin @(negedge clk); #1; g++; end
    if (g >= 200) fail_now("beat2_timeout");
    @(posedge clk); #1;
    check("pre_rst_wvalid", m_wvalid_o, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_awvalid", m_awvalid_o, 0);
    check("mid_rst_wvalid", m_wvalid_o, 0);
    check("mid_rst_wlast", m_wlast_o, 0);
    check("mid_rst_bready", m_bready_o, 0);
    check("mid_rst_frame_done", frame_done_o, 0);
    check("mid_rst_err", err_o, 0);
    check("mid_rst_awaddr", m_awaddr_o, 32'h1000);
    exp_aw_q.delete();
    exp_w_q.delete();
    mdl_pix = 0; mdl_words = 0; mdl_bursts = 0;
    w_beats = aw_hs * BLEN;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync;
    pval = 8'hC0;
    feed(32);
    drain;
    check("post_rst_done_count", fd_count, exp_frames);
    check("post_rst_err", err_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
